// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: state encoding,
// boolean constants and the default line-count exponent.
package icache_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    localparam int ICACHE_INDEX_BITS = 6;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_MISS = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and mem_ctrl-side signal bundle of the instruction cache.
// master = cache view, slave = fetch stage / mem_ctrl view.
interface icache_if;

    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        busy;
    logic        inst_IF_req;
    logic [31:0] inst_IF_addr;
    logic        inst_IF_flag;
    logic [31:0] inst_IF;

    modport master (
        input  fetch_req, fetch_pc, inst_IF_flag, inst_IF,
        output inst_valid, inst_out, inst_pc, busy, inst_IF_req, inst_IF_addr
    );

    modport slave (
        output fetch_req, fetch_pc, inst_IF_flag, inst_IF,
        input  inst_valid, inst_out, inst_pc, busy, inst_IF_req, inst_IF_addr
    );

endinterface

// File: rtl/icache_array.sv
// Line storage: valid bits, tags and one instruction word per line.
// Combinational read port, synchronous write port, valid bits cleared on rst.
module icache_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_reg;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (we && (wr_idx == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag/data carry no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between fetch and mem_ctrl, one word per line.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_wrong_flag,
    icache_if.master    bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    icache_state_e state_reg, state_next;
    logic [31:0]   miss_pc_reg, miss_pc_next;
    logic          pend_reg, pend_next;
    logic          inst_valid_reg, inst_valid_next;
    logic [31:0]   inst_out_reg, inst_out_next;
    logic [31:0]   inst_pc_reg, inst_pc_next;

    logic                  fill;
    logic                  hit;
    logic                  hit_acc;
    logic                  miss_acc;
    logic [INDEX_BITS-1:0] rd_idx;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;

    // A deferred response re-reads its own line, which was filled when the flag arrived.
    assign rd_idx = pend_reg ? miss_pc_reg[INDEX_BITS+1:2] : bus.fetch_pc[INDEX_BITS+1:2];
    assign hit    = rd_valid && (rd_tag == bus.fetch_pc[31:INDEX_BITS+2]);
    assign fill   = (state_reg == ICACHE_MISS) && bus.inst_IF_flag;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill),
        .wr_idx   (miss_pc_reg[INDEX_BITS+1:2]),
        .wr_tag   (miss_pc_reg[31:INDEX_BITS+2]),
        .wr_data  (bus.inst_IF)
    );

    always_comb begin
        state_next      = state_reg;
        miss_pc_next    = miss_pc_reg;
        pend_next       = pend_reg;
        inst_valid_next = FALSE;
        inst_out_next   = inst_out_reg;
        inst_pc_next    = inst_pc_reg;
        hit_acc         = FALSE;
        miss_acc        = FALSE;

        // The fill itself is not gated here: a flush coinciding with the flag still writes the line.
        if (jump_wrong_flag) begin
            state_next = ICACHE_IDLE;
            pend_next  = FALSE;
        end else begin
            case (state_reg)
                ICACHE_IDLE: begin
                    if (rdy) begin
                        if (pend_reg) begin
                            inst_valid_next = TRUE;
                            inst_out_next   = rd_data;
                            inst_pc_next    = miss_pc_reg;
                            pend_next       = FALSE;
                        end else if (bus.fetch_req) begin
                            if (hit) begin
                                inst_valid_next = TRUE;
                                inst_out_next   = rd_data;
                                inst_pc_next    = bus.fetch_pc;
                                hit_acc         = TRUE;
                            end else begin
                                state_next   = ICACHE_MISS;
                                miss_pc_next = {bus.fetch_pc[31:2], 2'b00};
                                miss_acc     = TRUE;
                            end
                        end
                    end
                end
                ICACHE_MISS: begin
                    if (bus.inst_IF_flag) begin
                        state_next = ICACHE_IDLE;
                        if (rdy) begin
                            inst_valid_next = TRUE;
                            inst_out_next   = bus.inst_IF;
                            inst_pc_next    = miss_pc_reg;
                        end else begin
                            pend_next = TRUE;
                        end
                    end
                end
                default: state_next = ICACHE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ICACHE_IDLE;
            miss_pc_reg    <= '0;
            pend_reg       <= FALSE;
            inst_valid_reg <= FALSE;
            inst_out_reg   <= '0;
            inst_pc_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            miss_pc_reg    <= miss_pc_next;
            pend_reg       <= pend_next;
            inst_valid_reg <= inst_valid_next;
            inst_out_reg   <= inst_out_next;
            inst_pc_reg    <= inst_pc_next;
        end
    end

    assign bus.inst_valid   = inst_valid_reg;
    assign bus.inst_out     = inst_out_reg;
    assign bus.inst_pc      = inst_pc_reg;
    assign bus.inst_IF_req  = (state_reg == ICACHE_MISS);
    assign bus.inst_IF_addr = miss_pc_reg;
    // Fetch stays held off until a stalled response has been delivered.
    assign bus.busy         = (state_reg == ICACHE_MISS) || pend_reg;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (hit_acc && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (miss_acc && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`else
    logic unused_stats;
    assign unused_stats = hit_acc ^ miss_acc;
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache: a line-level model (which PC each
// line holds and its word) predicts hit/miss and returned data.
module tb_icache;

    localparam int IB = 6;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic jump_wrong_flag;

    icache_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .jump_wrong_flag (jump_wrong_flag),
        .bus             (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: per line, whether it holds something, which full PC, and the word.
    bit          m_valid [1<<IB];
    logic [31:0] m_pc    [1<<IB];
    logic [31:0] m_data  [1<<IB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < (1 << IB); i++) m_valid[i] = 1'b0;
    endtask

    function automatic int line_of(input logic [31:0] pc);
        return int'((pc >> 2) % (1 << IB));
    endfunction

    task automatic model_fill(input logic [31:0] pc, input logic [31:0] data);
        m_valid[line_of(pc)] = 1'b1;
        m_pc[line_of(pc)]    = pc;
        m_data[line_of(pc)]  = data;
    endtask

    // mode: 0..2 normal, 3 flush before flag, 4 flush with flag, 5 stall at flag
    task automatic xact(input logic [31:0] pc, input int mode, input logic [31:0] data);
        bit hit;
        int ln;
        ln  = line_of(pc);
        hit = m_valid[ln] && (m_pc[ln] == pc);
        $display("txn pc=%h mode=%0d hit=%0d data=%h", pc, mode, hit, data);

        bus.fetch_req   = 1'b1;
        bus.fetch_pc    = pc;
        rdy             = !(hit && mode == 5);
        jump_wrong_flag = hit && mode == 3;
        step();
        bus.fetch_req   = 1'b0;
        rdy             = 1'b1;
        jump_wrong_flag = 1'b0;

        if (hit) begin
            if (mode == 3 || mode == 5) begin
                check("blocked_hit_valid", bus.inst_valid, 1'b0);
            end else begin
                check("hit_valid", bus.inst_valid, 1'b1);
                check("hit_data", bus.inst_out, m_data[ln]);
                check("hit_pc", bus.inst_pc, pc);
                check("hit_no_req", bus.inst_IF_req, 1'b0);
            end
            return;
        end

        check("miss_req", bus.inst_IF_req, 1'b1);
        check("miss_addr", bus.inst_IF_addr, pc);
        check("miss_busy", bus.busy, 1'b1);
        check("miss_valid", bus.inst_valid, 1'b0);
        repeat ($urandom_range(0, 2)) begin
            bus.fetch_req = $urandom_range(0, 1);
            bus.fetch_pc  = $urandom;
            step();
            bus.fetch_req = 1'b0;
            check("miss_req_held", bus.inst_IF_req, 1'b1);
            check("miss_addr_held", bus.inst_IF_addr, pc);
        end

        if (mode == 3) begin
            jump_wrong_flag = 1'b1;
            step();
            jump_wrong_flag = 1'b0;
            check("flush_req", bus.inst_IF_req, 1'b0);
            check("flush_busy", bus.busy, 1'b0);
            check("flush_valid", bus.inst_valid, 1'b0);
            return;
        end

        bus.inst_IF_flag = 1'b1;
        bus.inst_IF      = data;
        if (mode == 4) begin
            jump_wrong_flag = 1'b1;
            step();
            jump_wrong_flag  = 1'b0;
            bus.inst_IF_flag = 1'b0;
            check("flushfill_valid", bus.inst_valid, 1'b0);
            check("flushfill_req", bus.inst_IF_req, 1'b0);
            check("flushfill_busy", bus.busy, 1'b0);
        end else if (mode == 5) begin
            rdy = 1'b0;
            step();
            bus.inst_IF_flag = 1'b0;
            check("stall_valid", bus.inst_valid, 1'b0);
            check("stall_req", bus.inst_IF_req, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                step();
                check("stall_hold_valid", bus.inst_valid, 1'b0);
            end
            rdy = 1'b1;
            step();
            check("stall_resp_valid", bus.inst_valid, 1'b1);
            check("stall_resp_data", bus.inst_out, data);
            check("stall_resp_pc", bus.inst_pc, pc);
            check("stall_resp_busy", bus.busy, 1'b0);
        end else begin
            step();
            bus.inst_IF_flag = 1'b0;
            check("fill_valid", bus.inst_valid, 1'b1);
            check("fill_data", bus.inst_out, data);
            check("fill_pc", bus.inst_pc, pc);
            check("fill_req_drop", bus.inst_IF_req, 1'b0);
            check("fill_busy", bus.busy, 1'b0);
        end
        model_fill(pc, data);
        step();
        check("post_valid", bus.inst_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        rdy              = 1'b1;
        jump_wrong_flag  = 1'b0;
        bus.fetch_req    = 1'b0;
        bus.fetch_pc     = '0;
        bus.inst_IF_flag = 1'b0;
        bus.inst_IF      = '0;
        model_clear();
        step();
        step();
        rst = 1'b0;
        check("rst_valid", bus.inst_valid, 1'b0);
        check("rst_out", bus.inst_out, 32'h0);
        check("rst_pc", bus.inst_pc, 32'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_req", bus.inst_IF_req, 1'b0);
        check("rst_addr", bus.inst_IF_addr, 32'h0);

        // Cold miss and a second line
        xact(32'h0000_1000, 0, 32'h0050_0093);
        xact(32'h0000_1004, 0, 32'h0010_0113);

        // Back-to-back hits
        $display("txn stream 1000/1004");
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h0000_1000;
        step();
        check("stream0_valid", bus.inst_valid, 1'b1);
        check("stream0_data", bus.inst_out, 32'h0050_0093);
        check("stream0_pc", bus.inst_pc, 32'h0000_1000);
        bus.fetch_pc = 32'h0000_1004;
        step();
        bus.fetch_req = 1'b0;
        check("stream1_valid", bus.inst_valid, 1'b1);
        check("stream1_data", bus.inst_out, 32'h0010_0113);
        check("stream1_pc", bus.inst_pc, 32'h0000_1004);
        check("stream_no_req", bus.inst_IF_req, 1'b0);
        step();

        // Conflict eviction, mispredict, flush with flag, stall
        xact(32'h0000_1100, 0, 32'h1111_1111);
        xact(32'h0000_1000, 0, 32'h0050_0093);
        xact(32'h0000_2000, 3, 32'h2222_2222);
        xact(32'h0000_2000, 0, 32'h2222_2222);
        xact(32'h0000_3000, 4, 32'hDEAD_BEEF);
        xact(32'h0000_3000, 0, 32'h0BAD_0BAD);
        xact(32'h0000_3400, 5, 32'h3434_3434);
        xact(32'h0000_3400, 0, 32'h0);

        // Stray flag while idle
        $display("txn stray flag");
        bus.inst_IF_flag = 1'b1;
        bus.inst_IF      = 32'hFFFF_0000;
        step();
        bus.inst_IF_flag = 1'b0;
        check("stray_valid", bus.inst_valid, 1'b0);
        check("stray_req", bus.inst_IF_req, 1'b0);
        xact(32'h0000_1000, 0, 32'h0);

        // Reset in the middle of a miss invalidates everything
        $display("txn rst mid-miss pc=00005000");
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h0000_5000;
        step();
        bus.fetch_req = 1'b0;
        check("rstmiss_req", bus.inst_IF_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        check("rstmiss_req_drop", bus.inst_IF_req, 1'b0);
        check("rstmiss_busy", bus.busy, 1'b0);
        check("rstmiss_valid", bus.inst_valid, 1'b0);
        xact(32'h0000_1000, 0, 32'h0050_0093);

        // Random traffic over a small aliased address pool
        for (int n = 0; n < 200; n++) begin
            logic [31:0] pc;
            pc = 32'h0000_4000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 7) << 2);
            xact(pc, $urandom_range(0, 5), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
